// File: rtl/sat_addsub_pipe.sv
// sat_addsub_pipe: two-stage pipelined saturating add/sub with valid/ready.
// The adder is built from LANE-bit carry-lookahead groups. In full mode the
// group carries chain across the word. In packed mode every lane is an
// independent saturating adder. packed_mode selects packed operation.
module sat_addsub_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANE  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    input  logic                      sub,
    input  logic                      packed_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          s,
    output logic                      cout,
    output logic [(WIDTH/LANE)-1:0]   ovfl,
    output logic                      neg,
    output logic                      zero
);

    localparam int unsigned NLANES = WIDTH / LANE;

    localparam logic [LANE-1:0]  LANE_MAX = {1'b0, {(LANE-1){1'b1}}};
    localparam logic [LANE-1:0]  LANE_MIN = {1'b1, {(LANE-1){1'b0}}};
    localparam logic [WIDTH-1:0] WORD_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] WORD_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Operation captured in stage 1
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic             pk;
    } op_t;

    // Result and flags captured in stage 2
    typedef struct packed {
        logic [WIDTH-1:0]  s;
        logic              cout;
        logic [NLANES-1:0] ovfl;
        logic              neg;
        logic              zero;
    } res_t;

    op_t  s1_q;
    op_t  op_in;
    res_t r2_q;
    res_t res_c;
    logic v1_q;
    logic v2_q;
    logic accept;
    logic adv2;
    logic pop;

    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  gen;
    logic [WIDTH-1:0]  prop;
    logic [WIDTH-1:0]  carry;
    logic [WIDTH-1:0]  sum_raw;
    logic [WIDTH-1:0]  sat;
    logic [NLANES-1:0] grp_ci;
    logic [NLANES-1:0] grp_co;
    logic [NLANES-1:0] ovfl_c;
    logic              la_c;
    logic              term;
    logic [1:0]        ovf2;

    // Returns {positive overflow, negative overflow} for one span
    function automatic logic [1:0] span_ovf(input logic sa, input logic sb,
                                            input logic ss, input logic is_sub);
        logic pos;
        logic negv;
        if (is_sub) begin
            pos  = ~sa &  sb &  ss;
            negv =  sa & ~sb & ~ss;
        end else begin
            pos  = ~sa & ~sb &  ss;
            negv =  sa &  sb & ~ss;
        end
        return {pos, negv};
    endfunction

    // Handshake: S2 advances when it is empty or being drained
    assign in_ready = ~v1_q | ~v2_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign adv2     = v1_q & (~v2_q | out_ready);
    assign pop      = v2_q & out_ready;

    assign op_in = '{a: a, b: b, sub: sub, pk: packed_mode};

    // Carry-lookahead adder: each carry is a sum of products of g/p terms
    always_comb begin
        b_eff  = s1_q.sub ? ~s1_q.b : s1_q.b;
        gen    = s1_q.a & b_eff;
        prop   = s1_q.a ^ b_eff;
        carry  = '0;
        grp_ci = '0;
        grp_co = '0;
        la_c   = 1'b0;
        term   = 1'b0;
        for (int unsigned gi = 0; gi < NLANES; gi++) begin
            if (gi == 0 || s1_q.pk) begin
                grp_ci[gi] = s1_q.sub;
            end else begin
                grp_ci[gi] = grp_co[gi-1];
            end
            for (int unsigned i = 0; i <= LANE; i++) begin
                la_c = grp_ci[gi];
                for (int unsigned k = 0; k < i; k++) begin
                    la_c = la_c & prop[gi*LANE + k];
                end
                for (int unsigned k = 0; k < i; k++) begin
                    term = gen[gi*LANE + k];
                    for (int unsigned m = k + 1; m < i; m++) begin
                        term = term & prop[gi*LANE + m];
                    end
                    la_c = la_c | term;
                end
                if (i < LANE) begin
                    carry[gi*LANE + i] = la_c;
                end else begin
                    grp_co[gi] = la_c;
                end
            end
        end
        sum_raw = prop ^ carry;
    end

    // Saturation per span and flag generation from the saturated result
    always_comb begin
        sat    = sum_raw;
        ovfl_c = '0;
        ovf2   = 2'b00;
        if (s1_q.pk) begin
            for (int unsigned gi = 0; gi < NLANES; gi++) begin
                ovf2 = span_ovf(s1_q.a[gi*LANE + LANE - 1], s1_q.b[gi*LANE + LANE - 1],
                                sum_raw[gi*LANE + LANE - 1], s1_q.sub);
                if (ovf2[1]) begin
                    sat[gi*LANE +: LANE] = LANE_MAX;
                end else if (ovf2[0]) begin
                    sat[gi*LANE +: LANE] = LANE_MIN;
                end
                ovfl_c[gi] = |ovf2;
            end
        end else begin
            ovf2 = span_ovf(s1_q.a[WIDTH-1], s1_q.b[WIDTH-1], sum_raw[WIDTH-1], s1_q.sub);
            if (ovf2[1]) begin
                sat = WORD_MAX;
            end else if (ovf2[0]) begin
                sat = WORD_MIN;
            end
            ovfl_c[NLANES-1] = |ovf2;
        end
        res_c.s    = sat;
        res_c.cout = s1_q.pk ? 1'b0 : grp_co[NLANES-1];
        res_c.ovfl = ovfl_c;
        res_c.neg  = s1_q.pk ? 1'b0 : sat[WIDTH-1];
        res_c.zero = (sat == '0);
    end

    // Stage 1: capture the operation on accept, empty when it moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else if (accept) begin
            v1_q <= 1'b1;
            s1_q <= op_in;
        end else if (adv2) begin
            v1_q <= 1'b0;
        end
    end

    // Stage 2: capture the result on advance, empty when popped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q <= 1'b0;
            r2_q <= '0;
        end else if (adv2) begin
            v2_q <= 1'b1;
            r2_q <= res_c;
        end else if (pop) begin
            v2_q <= 1'b0;
        end
    end

    assign out_valid = v2_q;
    assign s         = r2_q.s;
    assign cout      = r2_q.cout;
    assign ovfl      = r2_q.ovfl;
    assign neg       = r2_q.neg;
    assign zero      = r2_q.zero;

endmodule
